// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//   Two-entry skid buffer between a valid/ready producer and a downstream
//   enable-register stage.  in_ready comes straight from a flop, so the
//   upstream ready path is cut.  The second (skid) register catches the word
//   that was already in flight when downstream stalled.
//
// Ports
//   clkrst_core_clk  in   clock, all state changes on the rising edge
//   clkrst_core_rst  in   synchronous active-high reset (beats flush/handshakes)
//   in_valid         in   upstream offers in_data
//   in_ready         out  block can take a word (registered)
//   in_data          in   upstream word, WIDTH bits
//   out_valid        out  out_data holds a valid word
//   out_ready        in   downstream takes the word
//   out_data         out  head word, straight from the main register
//   flush            in   drop every held word (data registers keep values)
//   count            out  occupancy 0..2
// -----------------------------------------------------------------------------
module skid_buffer #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clkrst_core_clk,
   input  logic             clkrst_core_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       count
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             in_ready_q;
   logic [WIDTH-1:0] main_q, skid_q;

   logic in_fire, out_fire;
   logic load_main_in;    // main <- in_data
   logic load_main_skid;  // main <- skid
   logic load_skid;       // skid <- in_data

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   // Next state and register enables.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               load_main_in = 1'b1;
               state_d      = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_d   = ST_FULL;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so no word can arrive.
            if (out_fire) begin
               load_main_skid = 1'b1;
               state_d        = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush empties the buffer and discards this cycle's accepted word;
      // the data registers are left untouched.
      if (flush) begin
         state_d        = ST_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clkrst_core_clk) begin
      if (clkrst_core_rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= RESET_VAL;
         skid_q     <= RESET_VAL;
      end else begin
         state_q    <= state_d;
         // Registered copy of "not FULL" keeps out_ready off the in_ready path.
         in_ready_q <= (state_d != ST_FULL);
         if (load_main_in)
            main_q <= in_data;
         else if (load_main_skid)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= in_data;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign count     = state_q;

endmodule

// File: tb/tb_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer
//   Directed vectors with hand-computed expectations for skid_buffer (WIDTH=8).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_skid_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       flush;
   logic [1:0] count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   skid_buffer #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clkrst_core_clk (clk),
      .clkrst_core_rst (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .flush           (flush),
      .count           (count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the full output state in one call.
   task automatic chk_st(input string tag, input logic ov, input logic ir,
                         input logic [1:0] cnt, input logic [7:0] od);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
      chk({tag, ".count"},     32'(count),     32'(cnt));
      chk({tag, ".out_data"},  32'(out_data),  32'(od));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;

      // Reset state
      step(); step();
      chk_st("reset", 1'b0, 1'b1, 2'd0, 8'h00);
      rst = 1'b0;

      // Back-to-back stream with out_ready=1
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 8'h11; step(); chk_st("stream11", 1'b1, 1'b1, 2'd1, 8'h11);
      in_data = 8'h22; step(); chk_st("stream22", 1'b1, 1'b1, 2'd1, 8'h22);
      in_data = 8'h33; step(); chk_st("stream33", 1'b1, 1'b1, 2'd1, 8'h33);
      in_valid = 1'b0; step(); chk_st("drain", 1'b0, 1'b1, 2'd0, 8'h33);

      // Stall: fill to FULL, third offer refused, then drain in order
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'hA1; step(); chk_st("fillA1", 1'b1, 1'b1, 2'd1, 8'hA1);
      in_data = 8'hB2; step(); chk_st("fillB2", 1'b1, 1'b0, 2'd2, 8'hA1);
      in_data = 8'hC3; step(); chk_st("refC3",  1'b1, 1'b0, 2'd2, 8'hA1);
      step();                  chk_st("holdC3", 1'b1, 1'b0, 2'd2, 8'hA1);
      out_ready = 1'b1;
      step(); chk_st("outB2", 1'b1, 1'b1, 2'd1, 8'hB2);
      step(); chk_st("outC3", 1'b1, 1'b1, 2'd1, 8'hC3);
      in_valid = 1'b0;
      step(); chk_st("emptyC3", 1'b0, 1'b1, 2'd0, 8'hC3);

      // FULL with one-cycle out_ready; 0x55 taken the cycle after
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'hA1; step();
      in_data = 8'hB2; step(); chk("full2.count", 32'(count), 32'd2);
      in_data = 8'h55; out_ready = 1'b1;
      step(); chk_st("pop1", 1'b1, 1'b1, 2'd1, 8'hB2);
      out_ready = 1'b0;
      step(); chk_st("take55", 1'b1, 1'b0, 2'd2, 8'hB2);
      in_valid = 1'b0; out_ready = 1'b1;
      step(); chk_st("out55", 1'b1, 1'b1, 2'd1, 8'h55);
      step(); chk_st("empty55", 1'b0, 1'b1, 2'd0, 8'h55);

      // Flush in FULL with a concurrent 0x77 offer
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'h01; step();
      in_data = 8'h02; step(); chk("full3.count", 32'(count), 32'd2);
      in_data = 8'h77; flush = 1'b1;
      step(); chk_st("flush", 1'b0, 1'b1, 2'd0, 8'h01);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flush.idle_valid", 32'(out_valid), 32'd0);
         chk("flush.no77", 32'(out_data == 8'h77), 32'd0);
      end
      in_valid = 1'b1; in_data = 8'h88;
      step(); chk_st("post_flush88", 1'b1, 1'b1, 2'd1, 8'h88);

      // Reset in the middle of streaming with out_ready toggling
      for (int i = 0; i < 6; i++) begin
         in_data   = 8'h40 + 8'(i);
         out_ready = i[0];
         step();
      end
      in_data = 8'h99; out_ready = 1'b1; flush = 1'b1; rst = 1'b1;
      step(); chk_st("mid_reset", 1'b0, 1'b1, 2'd0, 8'h00);
      rst = 1'b0; flush = 1'b0; in_data = 8'h5A;
      step(); chk_st("after_reset5A", 1'b1, 1'b1, 2'd1, 8'h5A);
      in_valid = 1'b0;
      step(); chk_st("after_reset_drain", 1'b0, 1'b1, 2'd0, 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data width in bits.
REQ-002 SHALL have parameter RESET_VAL, default 0, the value loaded into both data registers on reset.
REQ-003 SHALL have port clkrst_core_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clkrst_core_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a word; driven directly from a flop.
REQ-007 SHALL have port in_data, input, WIDTH bits: upstream word.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream enable-register stage takes the word.
REQ-010 SHALL have port out_data, output, WIDTH bits: the head word, driven directly from the main data register.
REQ-011 SHALL have port flush, input, 1 bit: discard all held words.
REQ-012 SHALL have port count, output, 2 bits: occupancy 0..2.

Function
REQ-013 SHALL define in_fire as in_valid and in_ready, and out_fire as out_valid and out_ready.
REQ-014 SHALL implement a 3-state FSM: EMPTY (count 0), ONE (main register valid, count 1), FULL (main and skid registers valid, count 2).
REQ-015 SHALL drive out_valid high in ONE and FULL and low in EMPTY.
REQ-016 SHALL drive in_ready high in EMPTY and ONE and low in FULL; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 In EMPTY on in_fire, SHALL load main with in_data and go to ONE, so out_valid rises 1 cycle after acceptance.
REQ-018 In ONE on in_fire and out_fire together, SHALL load main with in_data and stay in ONE.
REQ-019 In ONE on in_fire only, SHALL load skid with in_data and go to FULL.
REQ-020 In ONE on out_fire only, SHALL go to EMPTY.
REQ-021 In FULL on out_fire, SHALL copy skid into main and go to ONE; in FULL with no out_fire, SHALL hold all state.
REQ-022 SHALL deliver words in acceptance order, with no loss and no duplication.
REQ-023 When main is not loaded, SHALL hold its value, so out_data stays stable while out_valid is high and out_ready is low.
REQ-024 On flush (with reset low), SHALL go to EMPTY and drop any word accepted in that cycle; data registers SHALL keep their values.
REQ-025 In EMPTY, out_data SHALL show the last main value; it has no meaning while out_valid is low.
REQ-026 SHALL give count values EMPTY=0, ONE=1, FULL=2; count SHALL never be 3.

Reset
REQ-027 Reset SHALL take priority over flush and all handshakes.
REQ-028 On reset, SHALL go to EMPTY and set out_valid=0, in_ready=1, count=0, and main=skid=RESET_VAL, so out_data=RESET_VAL.
REQ-029 Reset asserted mid-transfer SHALL discard all held words, and no handshake SHALL complete in the reset cycle.
REQ-030 SHALL resume accepting data in the first cycle after reset deasserts.

Verification
REQ-031 Bench SHALL cover: reset with WIDTH=8 -> out_valid=0, in_ready=1, count=0, out_data=0x00.
REQ-032 Bench SHALL cover: push 0x11, 0x22, 0x33 on back-to-back cycles with out_ready=1 -> out_data 0x11, 0x22, 0x33 one cycle after each, count stays 1, in_ready stays 1.
REQ-033 Bench SHALL cover: out_ready=0, push 0xA1 then 0xB2 -> count=2, in_ready=0, out_data=0xA1 held; a third offer 0xC3 is not accepted. Then out_ready=1 -> 0xA1, 0xB2, 0xC3 in order.
REQ-034 Bench SHALL cover: in FULL, hold in_valid=1 with 0x55 and set out_ready=1 for one cycle -> next cycle ONE, out_data=0xB2, in_ready=1; 0x55 is accepted the cycle after.
REQ-035 Bench SHALL cover: in FULL, assert flush together with in_valid=1 carrying 0x77 -> next cycle count=0, out_valid=0, and 0x77 never appears on the output.
REQ-036 Bench SHALL cover: assert reset during continuous streaming with out_ready toggling -> next cycle matches REQ-031, and a word pushed after reset appears with 1-cycle latency.
